// File: rtl/bf_uart_pkg.sv
// Shared constants and FSM encoding for the brainfuck-core UART bridge.
package bf_uart_pkg;

  localparam logic [7:0] BF_OP_COMMA    = 8'h2C;
  localparam logic [7:0] BF_OP_DOT      = 8'h2E;
  localparam int         UART_DATA_BITS = 8;

  // One encoding shared by the serialiser and the deserialiser.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/bf_uart_bridge_if.sv
// Parallel character interface between the brainfuck core and the UART bridge.
interface bf_uart_bridge_if;

  logic       sendingChar;
  logic [7:0] sendedChar;
  logic       core_ready;
  logic [7:0] core_instr;
  logic       receivingChar;
  logic [7:0] receivedChar;

  modport master (
    output sendingChar, sendedChar, core_ready, core_instr,
    input  receivingChar, receivedChar
  );

  modport slave (
    input  sendingChar, sendedChar, core_ready, core_instr,
    output receivingChar, receivedChar
  );

endinterface

// File: rtl/bf_fifo.sv
// Synchronous first-word-fall-through byte FIFO, depth 2**AW.
module bf_fifo #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count guards every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bf_uart_bridge.sv
// UART 8N1 bridge for the brainfuck core's `.`/`,` character port.
// Define BF_UART_ECHO_EN to echo every accepted RX byte back out on uart_tx.
module bf_uart_bridge
  import bf_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             reset,
  bf_uart_bridge_if.slave  core,
  input  logic             uart_rx,
  output logic             uart_tx,
  output logic             tx_busy,
  output logic             tx_overflow,
  output logic             rx_overflow,
  output logic             rx_frame_err
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0] tx_din, tx_dout;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] rx_dout;
  logic       rx_accept, rx_drop, tx_drop, echo_lost, frame_err_set;

  bf_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .din   (tx_din),
    .pop   (tx_pop),
    .dout  (tx_dout),
    .empty (tx_empty),
    .full  (tx_full)
  );

  // ---------------------------------------------------------------- serialiser
  uart_state_e      tx_state, tx_state_d;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]       tx_bit, tx_bit_d;
  logic [7:0]       tx_data, tx_data_d;
  logic             tx_line;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_data  <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_data  <= tx_data_d;
      uart_tx  <= tx_line;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_data_d  = tx_data;
    tx_pop     = 1'b0;
    tx_line    = 1'b1;
    case (tx_state)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_data_d  = tx_dout;
          tx_cnt_d   = '0;
          tx_state_d = START;
        end
      end
      START: begin
        tx_line = 1'b0;
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = DATA;
        end else begin
          tx_cnt_d = tx_cnt + 1'b1;
        end
      end
      DATA: begin
        tx_line = tx_data[tx_bit];
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit == LAST_BIT) tx_state_d = STOP;
          else                    tx_bit_d   = tx_bit + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt + 1'b1;
        end
      end
      STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = IDLE;
        end else begin
          tx_cnt_d = tx_cnt + 1'b1;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  assign tx_busy = (tx_state != IDLE) || !tx_empty;

  // -------------------------------------------------------------- deserialiser
  logic             rx_meta, rx_sync;
  uart_state_e      rx_state, rx_state_d;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]       rx_bit, rx_bit_d;
  logic [7:0]       rx_shift, rx_shift_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d    = rx_state;
    rx_cnt_d      = rx_cnt;
    rx_bit_d      = rx_bit;
    rx_shift_d    = rx_shift;
    rx_push       = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state)
      IDLE: begin
        if (!rx_sync) begin
          rx_cnt_d   = '0;
          rx_state_d = START;
        end
      end
      START: begin
        // Re-check at mid start bit; a line already high again was a glitch.
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync ? IDLE : DATA;
        end else begin
          rx_cnt_d = rx_cnt + 1'b1;
        end
      end
      DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync, rx_shift[7:1]};
          if (rx_bit == LAST_BIT) rx_state_d = STOP;
          else                    rx_bit_d   = rx_bit + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt + 1'b1;
        end
      end
      STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d      = '0;
          rx_state_d    = IDLE;
          rx_push       = rx_sync;
          frame_err_set = !rx_sync;
        end else begin
          rx_cnt_d = rx_cnt + 1'b1;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  bf_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .din   (rx_shift),
    .pop   (rx_pop),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign rx_pop    = !rx_empty && core.core_ready && (core.core_instr == BF_OP_COMMA);
  assign rx_accept = rx_push && (!rx_full || rx_pop);
  assign rx_drop   = rx_push && !rx_accept;

  assign core.receivingChar = !rx_empty;
  assign core.receivedChar  = rx_empty ? 8'h00 : rx_dout;

  // ---------------------------------------------------------------- TX source
`ifdef BF_UART_ECHO_EN
  // The core byte has priority; a colliding echo is lost and flagged.
  assign tx_push   = core.sendingChar || rx_accept;
  assign tx_din    = core.sendingChar ? core.sendedChar : rx_shift;
  assign echo_lost = rx_accept && core.sendingChar;
`else
  assign tx_push   = core.sendingChar;
  assign tx_din    = core.sendedChar;
  assign echo_lost = 1'b0;
`endif

  assign tx_drop = tx_push && tx_full && !tx_pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_overflow  <= 1'b0;
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (tx_drop || echo_lost) tx_overflow  <= 1'b1;
      if (rx_drop)              rx_overflow  <= 1'b1;
      if (frame_err_set)        rx_frame_err <= 1'b1;
    end
  end

endmodule
